// File: rtl/io_port_pkg.sv
// io_port_pkg
//   Shared definitions for the CPU-facing IO port controller:
//   register addresses, STATUS bit positions, parameter defaults and the
//   STATUS packing helper.
//   Optional feature macro used by the RX buffer: IO_PORT_RX_FIFO_EN.
package io_port_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_RX_DEPTH = 4;

  // Register map (ADDR values)
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIR    = 2'd2;
  localparam logic [1:0] ADDR_PIN    = 2'd3;

  // STATUS bit positions
  localparam int STAT_RX_NE   = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_STB  = 2;
  localparam int STAT_RX_OVF  = 3;
  localparam int STAT_TX_OVF  = 4;
  localparam int STAT_BITS    = 5;

  // Field order matches the bit positions above (MSB first).
  typedef struct packed {
    logic tx_ovf;
    logic rx_ovf;
    logic tx_stb;
    logic rx_full;
    logic rx_ne;
  } status_t;

  function automatic logic [STAT_BITS-1:0] pack_status(input status_t s);
    return s;
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// io_rx_fifo
//   Receive buffer for bytes captured from the pins.
//   IO_PORT_RX_FIFO_EN defined  : RX_DEPTH-entry FIFO, pointers one bit wider
//                                 than the index so full/empty are distinct.
//   IO_PORT_RX_FIFO_EN undefined: single holding register, full == not_empty,
//                                 RX_DEPTH has no effect.
//   Ports:
//     clk, rst   - clock, asynchronous active-high reset (pointers/valid only)
//     push, din  - write request and data
//     pop        - read request; ignored when empty
//     head       - combinational head entry, 0 when empty
//     not_empty, full - occupancy flags
//     overflow   - one-cycle pulse when a push is discarded
module io_rx_fifo
  import io_port_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full,
  output logic             overflow
);

  // Legal RX_DEPTH is a power of two, at least 2; this block marks the
  // illegal region and generates nothing.
  if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_rx_depth_illegal
  end

`ifdef IO_PORT_RX_FIFO_EN

  localparam int AW = $clog2(RX_DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [RX_DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign not_empty = !empty;

  // A pop frees the slot the simultaneous push lands in, so on a full
  // FIFO the pop takes priority and the push still goes in.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

`else

  logic [WIDTH-1:0] hold_reg;
  logic             valid_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && valid_reg;
  assign do_push  = push && (!valid_reg || do_pop);
  assign overflow = push && valid_reg && !do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else if (do_push) begin
      valid_reg <= 1'b1;
    end else if (do_pop) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) hold_reg <= din;
  end

  assign head      = valid_reg ? hold_reg : '0;
  assign not_empty = valid_reg;
  assign full      = valid_reg;

`endif

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
//   CPU-mapped bidirectional IO port with a strobed receive path and an
//   acknowledged transmit path.
//   Feature macro: IO_PORT_RX_FIFO_EN selects an RX_DEPTH FIFO for RX;
//   otherwise RX is a single holding register.
//   Ports:
//     CLK, RST        - clock, asynchronous active-high reset
//     ADDR            - 0=DATA 1=STATUS 2=DIR 3=PIN
//     WR_EN, WDATA    - CPU write
//     RD_EN, RDATA    - CPU read strobe (side effects), combinational data
//     PORT            - pins; bit i driven from OUT_LAT[i] when DIR[i]=1
//     EXT_STB         - async strobe; rising edge captures PORT into RX
//     EXT_ACK         - async acknowledge of a TX byte
//     TX_STB          - high while a TX byte waits for acknowledge
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       ADDR,
  input  logic             WR_EN,
  input  logic             RD_EN,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  inout  wire  [WIDTH-1:0] PORT,
  input  logic             EXT_STB,
  input  logic             EXT_ACK,
  output logic             TX_STB
);

  // Synchronizers
  logic [WIDTH-1:0] port_s1_reg, port_s2_reg;
  logic             stb_s1_reg, stb_s2_reg, stb_d_reg;
  logic             ack_s1_reg, ack_s2_reg;

  // Architectural state
  logic [WIDTH-1:0] dir_reg, dir_next;
  logic [WIDTH-1:0] out_lat_reg, out_lat_next;
  logic             tx_stb_reg, tx_stb_next;
  logic             tx_ovf_reg, tx_ovf_next;
  logic             rx_ovf_reg, rx_ovf_next;

  // Decoded bus accesses
  logic wr_data, wr_dir, rd_data, rd_status;

  // RX buffer interface
  logic             rx_push;
  logic [WIDTH-1:0] rx_head;
  logic             rx_ne, rx_full, rx_overflow;

  assign wr_data   = WR_EN && (ADDR == ADDR_DATA);
  assign wr_dir    = WR_EN && (ADDR == ADDR_DIR);
  assign rd_data   = RD_EN && (ADDR == ADDR_DATA);
  assign rd_status = RD_EN && (ADDR == ADDR_STATUS);

  // PORT and EXT_STB share the same two-stage latency, so the byte pushed
  // on a detected edge is the pin value sampled alongside that edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      port_s1_reg <= '0;
      port_s2_reg <= '0;
      stb_s1_reg  <= 1'b0;
      stb_s2_reg  <= 1'b0;
      stb_d_reg   <= 1'b0;
      ack_s1_reg  <= 1'b0;
      ack_s2_reg  <= 1'b0;
    end else begin
      port_s1_reg <= PORT;
      port_s2_reg <= port_s1_reg;
      stb_s1_reg  <= EXT_STB;
      stb_s2_reg  <= stb_s1_reg;
      stb_d_reg   <= stb_s2_reg;
      ack_s1_reg  <= EXT_ACK;
      ack_s2_reg  <= ack_s1_reg;
    end
  end

  assign rx_push = stb_s2_reg && !stb_d_reg;

  io_rx_fifo #(
    .WIDTH    (WIDTH),
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rx_push),
    .din       (port_s2_reg),
    .pop       (rd_data),
    .head      (rx_head),
    .not_empty (rx_ne),
    .full      (rx_full),
    .overflow  (rx_overflow)
  );

  always_comb begin
    dir_next     = wr_dir ? WDATA : dir_reg;
    out_lat_next = out_lat_reg;
    tx_stb_next  = tx_stb_reg;
    // A STATUS read clears the sticky flags, but an overflow raised in the
    // same cycle keeps its flag set.
    tx_ovf_next  = tx_ovf_reg && !rd_status;
    rx_ovf_next  = (rx_ovf_reg && !rd_status) || rx_overflow;

    if (tx_stb_reg) begin
      if (ack_s2_reg) tx_stb_next = 1'b0;
      if (wr_data)    tx_ovf_next = 1'b1;
    end else if (wr_data) begin
      out_lat_next = WDATA;
      tx_stb_next  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dir_reg     <= '0;
      out_lat_reg <= '0;
      tx_stb_reg  <= 1'b0;
      tx_ovf_reg  <= 1'b0;
      rx_ovf_reg  <= 1'b0;
    end else begin
      dir_reg     <= dir_next;
      out_lat_reg <= out_lat_next;
      tx_stb_reg  <= tx_stb_next;
      tx_ovf_reg  <= tx_ovf_next;
      rx_ovf_reg  <= rx_ovf_next;
    end
  end

  // Read mux
  always_comb begin
    RDATA = '0;
    case (ADDR)
      ADDR_DATA:   RDATA = rx_head;
      ADDR_STATUS: RDATA[STAT_BITS-1:0] = pack_status('{
                     tx_ovf:  tx_ovf_reg,
                     rx_ovf:  rx_ovf_reg,
                     tx_stb:  tx_stb_reg,
                     rx_full: rx_full,
                     rx_ne:   rx_ne});
      ADDR_DIR:    RDATA = dir_reg;
      default:     RDATA = port_s2_reg;
    endcase
  end

  assign TX_STB = tx_stb_reg;

  // Per-bit tristate pin drivers
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    assign PORT[gi] = dir_reg[gi] ? out_lat_reg[gi] : 1'bz;
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;
  import io_port_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] ADDR;
  logic       WR_EN, RD_EN;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  wire  [7:0] PORT;
  logic       EXT_STB, EXT_ACK;
  logic       TX_STB;

  logic       drv_en;
  logic [7:0] drv_val;
  assign PORT = drv_en ? drv_val : 8'bz;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  io_port_ctrl #(.WIDTH(8), .RX_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WR_EN(WR_EN), .RD_EN(RD_EN),
    .WDATA(WDATA), .RDATA(RDATA), .PORT(PORT), .EXT_STB(EXT_STB),
    .EXT_ACK(EXT_ACK), .TX_STB(TX_STB)
  );

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK);
    ADDR = a; WDATA = d; WR_EN = 1'b1;
    @(negedge CLK);
    WR_EN = 1'b0;
    $display("wr addr=%0d data=%02h", a, d);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge CLK);
    ADDR = a; RD_EN = 1'b1;
    #1 d = RDATA;
    @(negedge CLK);
    RD_EN = 1'b0;
    $display("rd addr=%0d data=%02h", a, d);
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    ADDR = a;
    #1 d = RDATA;
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge CLK);
    drv_val = v; EXT_STB = 1'b1;
    repeat (4) @(negedge CLK);
    EXT_STB = 1'b0;
    repeat (4) @(negedge CLK);
    $display("strobe port=%02h", v);
  endtask

  task automatic ack_pulse();
    EXT_ACK = 1'b1;
    repeat (4) @(negedge CLK);
    EXT_ACK = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [7:0] got;
    RST = 1'b1; ADDR = ADDR_DATA; WR_EN = 0; RD_EN = 0; WDATA = 0;
    EXT_STB = 0; EXT_ACK = 0; drv_en = 0; drv_val = 0;
    #2;
    if (TX_STB !== 1'b0) begin errors++; $display("FAIL reset_tx_stb: got %b expected 0", TX_STB); end
    checks++;
    peek(ADDR_DATA, got);
    if (got !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", got); end
    checks++;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    peek(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL reset_status: got %02h expected 00", got); end
    checks++;
  endtask

  task automatic test_tx_handshake();
    logic [7:0] got;
    int n;
    cpu_write(ADDR_DIR, 8'hFF);
    cpu_read(ADDR_DIR, got);
    if (got !== 8'hFF) begin errors++; $display("FAIL dir_readback: got %02h expected FF", got); end
    checks++;
    cpu_write(ADDR_DATA, 8'hA5);
    if (PORT !== 8'hA5) begin errors++; $display("FAIL tx_port: got %02h expected A5", PORT); end
    checks++;
    if (TX_STB !== 1'b1) begin errors++; $display("FAIL tx_stb_set: got %b expected 1", TX_STB); end
    checks++;
    peek(ADDR_STATUS, got);
    if (got !== 8'h04) begin errors++; $display("FAIL tx_status: got %02h expected 04", got); end
    checks++;
    EXT_ACK = 1'b1;
    n = 0;
    while (TX_STB && n < 3) begin @(negedge CLK); n++; end
    if (TX_STB !== 1'b0) begin errors++; $display("FAIL tx_ack_clear: got %b expected 0 within 3 cycles", TX_STB); end
    checks++;
    EXT_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    if (PORT !== 8'hA5) begin errors++; $display("FAIL tx_port_hold: got %02h expected A5", PORT); end
    checks++;
  endtask

  task automatic test_tx_overflow();
    logic [7:0] got;
    cpu_write(ADDR_DATA, 8'h3C);
    cpu_write(ADDR_DATA, 8'hC3);
    peek(ADDR_STATUS, got);
    if (got !== 8'h14) begin errors++; $display("FAIL txovf_status: got %02h expected 14", got); end
    checks++;
    if (PORT !== 8'h3C) begin errors++; $display("FAIL txovf_port: got %02h expected 3C", PORT); end
    checks++;
    cpu_read(ADDR_STATUS, got);
    if (got !== 8'h14) begin errors++; $display("FAIL txovf_status_read: got %02h expected 14", got); end
    checks++;
    peek(ADDR_STATUS, got);
    if (got !== 8'h04) begin errors++; $display("FAIL txovf_cleared: got %02h expected 04", got); end
    checks++;
    ack_pulse();
    if (TX_STB !== 1'b0) begin errors++; $display("FAIL txovf_ack: got %b expected 0", TX_STB); end
    checks++;
    cpu_write(ADDR_DIR, 8'h00);
  endtask

  task automatic test_pin_dir();
    logic [7:0] got;
    drv_en = 1'b1; drv_val = 8'h96;
    repeat (3) @(negedge CLK);
    cpu_read(ADDR_PIN, got);
    if (got !== 8'h96) begin errors++; $display("FAIL pin_read: got %02h expected 96", got); end
    checks++;
    cpu_write(ADDR_STATUS, 8'hFF);
    cpu_write(ADDR_PIN, 8'hFF);
    peek(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL status_write_ignored: got %02h expected 00", got); end
    checks++;
    cpu_read(ADDR_DIR, got);
    if (got !== 8'h00) begin errors++; $display("FAIL dir_after_pin_write: got %02h expected 00", got); end
    checks++;
  endtask

  task automatic test_rx_order();
    logic [7:0] got, exp_status;
    logic [7:0] exp_q[$];
`ifdef IO_PORT_RX_FIFO_EN
    exp_status = 8'h03; exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
`else
    exp_status = 8'h0B; exp_q = '{8'h11, 8'h00, 8'h00, 8'h00};
`endif
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    cpu_read(ADDR_STATUS, got);
    if (got !== exp_status) begin errors++; $display("FAIL rxord_status: got %02h expected %02h", got, exp_status); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      cpu_read(ADDR_DATA, got);
      if (got !== exp_q[i]) begin errors++; $display("FAIL rxord_data%0d: got %02h expected %02h", i, got, exp_q[i]); end
      checks++;
    end
    cpu_read(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL rxord_status_empty: got %02h expected 00", got); end
    checks++;
  endtask

  task automatic test_rx_overflow();
    logic [7:0] got;
    logic [7:0] exp_q[$];
`ifdef IO_PORT_RX_FIFO_EN
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
`else
    exp_q = '{8'h11, 8'h00};
`endif
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44); strobe(8'h55);
    peek(ADDR_STATUS, got);
    if (got !== 8'h0B) begin errors++; $display("FAIL rxovf_peek: got %02h expected 0B", got); end
    checks++;
    cpu_read(ADDR_STATUS, got);
    if (got !== 8'h0B) begin errors++; $display("FAIL rxovf_read1: got %02h expected 0B", got); end
    checks++;
    cpu_read(ADDR_STATUS, got);
    if (got !== 8'h03) begin errors++; $display("FAIL rxovf_read2: got %02h expected 03", got); end
    checks++;
    foreach (exp_q[i]) begin
      cpu_read(ADDR_DATA, got);
      if (got !== exp_q[i]) begin errors++; $display("FAIL rxovf_data%0d: got %02h expected %02h", i, got, exp_q[i]); end
      checks++;
    end
    // Empty read must not have moved the pointers.
    strobe(8'h66);
    cpu_read(ADDR_DATA, got);
    if (got !== 8'h66) begin errors++; $display("FAIL rx_after_empty_read: got %02h expected 66", got); end
    checks++;
    cpu_read(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL rxovf_final_status: got %02h expected 00", got); end
    checks++;
  endtask

  task automatic test_push_pop_full();
    logic [7:0] got;
    logic [7:0] exp_q[$];
`ifdef IO_PORT_RX_FIFO_EN
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
`else
    strobe(8'h11);
    exp_q = '{8'h55};
`endif
    peek(ADDR_STATUS, got);
    if (got !== 8'h03) begin errors++; $display("FAIL pp_full_before: got %02h expected 03", got); end
    checks++;
    // Push lands on the third rising edge after EXT_STB rises; pop on the same edge.
    @(negedge CLK);
    drv_val = 8'h55; EXT_STB = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ADDR = ADDR_DATA; RD_EN = 1'b1;
    #1 got = RDATA;
    @(negedge CLK);
    RD_EN = 1'b0;
    if (got !== 8'h11) begin errors++; $display("FAIL pp_pop_data: got %02h expected 11", got); end
    checks++;
    peek(ADDR_STATUS, got);
    if (got !== 8'h03) begin errors++; $display("FAIL pp_status: got %02h expected 03", got); end
    checks++;
    EXT_STB = 1'b0;
    repeat (4) @(negedge CLK);
    foreach (exp_q[i]) begin
      cpu_read(ADDR_DATA, got);
      if (got !== exp_q[i]) begin errors++; $display("FAIL pp_data%0d: got %02h expected %02h", i, got, exp_q[i]); end
      checks++;
    end
    cpu_read(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL pp_final_status: got %02h expected 00", got); end
    checks++;
  endtask

  task automatic test_wr_rd_same_cycle();
    logic [7:0] got;
    strobe(8'h6A);
    @(negedge CLK);
    ADDR = ADDR_DATA; WDATA = 8'h5C; WR_EN = 1'b1; RD_EN = 1'b1;
    #1 got = RDATA;
    @(negedge CLK);
    WR_EN = 1'b0; RD_EN = 1'b0;
    if (got !== 8'h6A) begin errors++; $display("FAIL wrrd_data: got %02h expected 6A", got); end
    checks++;
    peek(ADDR_STATUS, got);
    if (got !== 8'h04) begin errors++; $display("FAIL wrrd_status: got %02h expected 04", got); end
    checks++;
    ack_pulse();
    if (TX_STB !== 1'b0) begin errors++; $display("FAIL wrrd_ack: got %b expected 0", TX_STB); end
    checks++;
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] got;
    drv_en = 1'b0;
    cpu_write(ADDR_DIR, 8'hFF);
    cpu_write(ADDR_DATA, 8'h77);
    if (PORT !== 8'h77 || TX_STB !== 1'b1) begin
      errors++; $display("FAIL rst_pretx: got port=%02h stb=%b expected 77/1", PORT, TX_STB);
    end
    checks++;
    #2 RST = 1'b1;
    #1;
    if (TX_STB !== 1'b0) begin errors++; $display("FAIL rst_tx_stb: got %b expected 0", TX_STB); end
    checks++;
    peek(ADDR_DIR, got);
    if (got !== 8'h00) begin errors++; $display("FAIL rst_dir: got %02h expected 00", got); end
    checks++;
    peek(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL rst_status: got %02h expected 00", got); end
    checks++;
    peek(ADDR_PIN, got);
    if (got !== 8'h00) begin errors++; $display("FAIL rst_pin: got %02h expected 00", got); end
    checks++;
    // With the DUT released, the pins follow the bench driver alone.
    drv_en = 1'b1; drv_val = 8'h5A;
    #1;
    if (PORT !== 8'h5A) begin errors++; $display("FAIL rst_port_hiz: got %02h expected 5A", PORT); end
    checks++;
    @(negedge CLK);
    RST = 1'b0;
    ack_pulse();
    if (TX_STB !== 1'b0) begin errors++; $display("FAIL rst_ack_ignored: got %b expected 0", TX_STB); end
    checks++;
    peek(ADDR_STATUS, got);
    if (got !== 8'h00) begin errors++; $display("FAIL rst_final_status: got %02h expected 00", got); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_tx_handshake();
    test_tx_overflow();
    test_pin_dir();
    test_rx_order();
    test_rx_overflow();
    test_push_pop_full();
    test_wr_rd_same_cycle();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width of the CPU bus and the pin bus.
REQ-002 Parameter RX_DEPTH, default 4, power of two, at least 2: RX FIFO entry count.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port ADDR, input, 2 bits: register select; 0=DATA, 1=STATUS, 2=DIR, 3=PIN.
REQ-006 Port WR_EN, input, 1 bit: CPU write strobe, sampled on CLK.
REQ-007 Port RD_EN, input, 1 bit: CPU read strobe; read side effects occur on CLK.
REQ-008 Port WDATA, input, WIDTH bits: CPU write data.
REQ-009 Port RDATA, output, WIDTH bits: combinational read data for ADDR.
REQ-010 Port PORT, inout, WIDTH bits: pins; bit i is driven from OUT_LAT[i] when DIR[i]=1, else high-Z.
REQ-011 Port EXT_STB, input, 1 bit: asynchronous external strobe; each rising edge captures PORT into RX.
REQ-012 Port EXT_ACK, input, 1 bit: asynchronous external acknowledge for a TX transfer.
REQ-013 Port TX_STB, output, 1 bit: high while a TX byte awaits acknowledge.

Function
REQ-014 PORT, EXT_STB and EXT_ACK each SHALL pass through a 2-flop synchronizer before use.
REQ-015 A rising edge SHALL be detected on the synchronized EXT_STB; the pushed byte SHALL be the synchronized PORT value from the same cycle.
REQ-016 A DATA write SHALL load OUT_LAT and set TX_STB in the next cycle, but only when TX_STB=0.
REQ-017 A DATA write while TX_STB=1 SHALL be dropped and SHALL set sticky TX_OVF.
REQ-018 TX_STB SHALL clear on the first cycle in which the synchronized EXT_ACK is high.
REQ-019 A DATA read SHALL return the RX head combinationally; the pop SHALL occur at that CLK edge.
REQ-020 A DATA read from an empty RX SHALL return 0 and SHALL leave the pointers unchanged.
REQ-021 A push to a full RX SHALL be discarded and SHALL set sticky RX_OVF.
REQ-022 When a push and a pop occur in the same cycle on a full FIFO, the pop SHALL win and the push SHALL be accepted, with no overflow.
REQ-023 The FIFO pointers SHALL be log2(RX_DEPTH)+1 bits wide and SHALL wrap modulo 2*RX_DEPTH.
REQ-024 STATUS SHALL read as {0..., TX_OVF, RX_OVF, TX_STB, RX_FULL, RX_NE}, bits 4..0.
REQ-025 A STATUS read SHALL clear RX_OVF and TX_OVF at the CLK edge; if a new overflow occurs in the same cycle, that flag SHALL remain set.
REQ-026 DIR SHALL be read/write; PIN SHALL be read-only, returning the synchronized PORT value; writes to STATUS and PIN SHALL be ignored.
REQ-027 WR_EN and RD_EN high in the same cycle SHALL perform both operations.

Reset
REQ-028 While RST=1, the following SHALL be 0 asynchronously: DIR, OUT_LAT, TX_STB, both sticky flags, the FIFO pointers and the synchronizers; PORT SHALL be fully high-Z.
REQ-029 A reset during a pending TX SHALL abandon the transfer; EXT_ACK after reset SHALL have no effect.
REQ-030 FIFO contents SHALL NOT require reset; RDATA SHALL be 0 for DATA reads after reset.

Configuration
REQ-031 Macro IO_PORT_RX_FIFO_EN SHALL control the RX buffer.
- Defined: RX SHALL be the RX_DEPTH FIFO described above.
- Undefined: RX SHALL be a single holding register; RX_FULL SHALL equal RX_NE; RX_DEPTH SHALL be ignored.

Structure
REQ-032 Register address constants, STATUS bit positions and the WIDTH default SHALL live in shared package io_port_pkg.
REQ-033 The RX buffer SHALL be sub-module io_rx_fifo, parameterized by WIDTH and RX_DEPTH.

Verification
REQ-034 Scenario TX handshake:
- Write DIR=0xFF, then DATA=0xA5.
- PORT=0xA5 and TX_STB=1 from the next cycle.
- Assert EXT_ACK; TX_STB=0 within 3 cycles.
REQ-035 Scenario RX order:
- DIR=0; PORT=0x11, 0x22, 0x33, 0x44 with a strobe each.
- STATUS=0x03.
- Four DATA reads return 0x11, 0x22, 0x33, 0x44; then STATUS=0x00.
REQ-036 Scenario RX overflow:
- Five strobes into the depth-4 FIFO.
- STATUS=0x0B; the FIFO holds the first four bytes.
- The next STATUS read returns 0x0B; the following read returns 0x03.
REQ-037 Scenario push and pop together on a full FIFO: no overflow, STATUS stays 0x03, and the new byte is read last.
REQ-038 Scenario TX overflow:
- Write DATA twice without EXT_ACK.
- STATUS=0x14; PORT keeps the first byte.
REQ-039 Scenario reset:
- Assert RST mid-TX with DIR=0xFF.
- PORT is high-Z and all outputs are 0 immediately, without waiting for a clock edge.
